// File: rtl/shift_pkg.sv
// Shared types and instruction field positions for the operand-2 shifter.
package shift_pkg;

    localparam int unsigned MAX_W = 64;

    localparam int unsigned AMT_MSB  = 11;
    localparam int unsigned AMT_LSB  = 7;
    localparam int unsigned ROT_MSB  = 11;
    localparam int unsigned ROT_LSB  = 8;
    localparam int unsigned TYPE_MSB = 6;
    localparam int unsigned TYPE_LSB = 5;
    localparam int unsigned REG_BIT  = 4;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // Result is zero-extended to MAX_W so one type serves every WIDTH.
    typedef struct packed {
        logic [MAX_W-1:0] result;
        logic             carry;
    } shift_res_t;

endpackage

// File: rtl/shift_core.sv
// Combinational ARM operand-2 shifter: offset, rotated immediate, immediate- and register-shift.
module shift_core
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OFF_W = 12
) (
    input  logic [WIDTH-1:0] val_rm,
    input  logic [7:0]       val_rs,
    input  logic [11:0]      shift_operand,
    input  logic             immediate,
    input  logic             mem_type,
    input  logic             carry_in,
    output shift_res_t       res_c
);

    localparam int unsigned LOG_W = $clog2(WIDTH);
    localparam logic [LOG_W:0] W_AMT = (LOG_W+1)'(WIDTH);

    // Rotate right by r; a zero rotation yields v because v << WIDTH is 0.
    function automatic logic [WIDTH-1:0] ror_w(input logic [WIDTH-1:0] v, input logic [LOG_W-1:0] r);
        return (v >> r) | (v << (W_AMT - {1'b0, r}));
    endfunction

    shift_type_e      typ;
    logic [4:0]       imm_amt;
    logic [7:0]       amt;
    logic [WIDTH:0]   lsl_ext;
    logic [WIDTH:0]   lsr_ext;
    logic [WIDTH:0]   asr_ext;
    logic [WIDTH-1:0] ror_v;
    logic [LOG_W-1:0] rot_m;
    logic [WIDTH-1:0] imm_v;
    logic [OFF_W-1:0] off;
    logic [WIDTH-1:0] result;
    logic             carry;

    // The extra bit beside each shifted value captures the last bit shifted out,
    // which also gives the amount>=WIDTH cases for free.
    always_comb begin
        typ     = shift_type_e'(shift_operand[TYPE_MSB:TYPE_LSB]);
        imm_amt = shift_operand[AMT_MSB:AMT_LSB];
        amt     = shift_operand[REG_BIT] ? val_rs : {3'b000, imm_amt};
        lsl_ext = {1'b0, val_rm} << amt;
        lsr_ext = {val_rm, 1'b0} >> amt;
        asr_ext = $unsigned($signed({val_rm, 1'b0}) >>> amt);
        ror_v   = ror_w(val_rm, amt[LOG_W-1:0]);
        rot_m   = LOG_W'({shift_operand[ROT_MSB:ROT_LSB], 1'b0});
        imm_v   = ror_w(WIDTH'(shift_operand[7:0]), rot_m);
        off     = shift_operand[OFF_W-1:0];
        result  = val_rm;
        carry   = carry_in;

        if (mem_type) begin
            result = {{(WIDTH-OFF_W){off[OFF_W-1]}}, off};
        end else if (immediate) begin
            result = imm_v;
            carry  = (shift_operand[ROT_MSB:ROT_LSB] == 4'd0) ? carry_in : imm_v[WIDTH-1];
        end else if (amt == 8'd0) begin
            // Register amount 0 passes Rm through; immediate #0 has special meanings.
            if (!shift_operand[REG_BIT]) begin
                case (typ)
                    SH_LSL: ;
                    SH_LSR: begin
                        result = '0;
                        carry  = val_rm[WIDTH-1];
                    end
                    SH_ASR: begin
                        result = {WIDTH{val_rm[WIDTH-1]}};
                        carry  = val_rm[WIDTH-1];
                    end
                    SH_ROR: begin
                        result = {carry_in, val_rm[WIDTH-1:1]};
                        carry  = val_rm[0];
                    end
                endcase
            end
        end else begin
            case (typ)
                SH_LSL: begin
                    result = lsl_ext[WIDTH-1:0];
                    carry  = lsl_ext[WIDTH];
                end
                SH_LSR: begin
                    result = lsr_ext[WIDTH:1];
                    carry  = lsr_ext[0];
                end
                SH_ASR: begin
                    result = asr_ext[WIDTH:1];
                    carry  = asr_ext[0];
                end
                SH_ROR: begin
                    result = ror_v;
                    carry  = ror_v[WIDTH-1];
                end
            endcase
        end

        res_c.result = MAX_W'(result);
        res_c.carry  = carry;
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined operand-2 shifter: shift_core followed by a STAGES-deep elastic register chain.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned OFF_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [7:0]       val_rs,
    input  logic [11:0]      shift_operand,
    input  logic             immediate,
    input  logic             mem_type,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] second_value,
    output logic             carry_out
);

    shift_res_t        core_res_c;
    shift_res_t        stage_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv_c;

    shift_core #(
        .WIDTH (WIDTH),
        .OFF_W (OFF_W)
    ) u_core (
        .val_rm        (val_rm),
        .val_rs        (val_rs),
        .shift_operand (shift_operand),
        .immediate     (immediate),
        .mem_type      (mem_type),
        .carry_in      (carry_in),
        .res_c         (core_res_c)
    );

    // A stage advances if it or any stage downstream is empty, or the consumer drains.
    always_comb begin
        logic drain;
        drain = out_ready;
        adv_c = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            drain    = drain | ~valid_q[i];
            adv_c[i] = drain;
        end
    end

    assign in_ready = adv_c[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            if (adv_c[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    stage_q[0] <= core_res_c;
                end
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (adv_c[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid    = valid_q[STAGES-1];
    assign second_value = stage_q[STAGES-1].result[WIDTH-1:0];
    assign carry_out    = stage_q[STAGES-1].carry;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe at STAGES = 1, 2 and 3 (instances 0, 1, 2).
module tb_shift_unit_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_valid = '0;
    logic [2:0]  in_ready;
    logic [31:0] val_rm = '0;
    logic [7:0]  val_rs = '0;
    logic [11:0] shift_operand = '0;
    logic        immediate = 1'b0;
    logic        mem_type = 1'b0;
    logic        carry_in = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  out_valid;
    logic [31:0] sv [3];
    logic        co [3];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [32:0] sb [$];
    logic [32:0] mon_exp;
    bit          rnd_stop;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        shift_unit_pipe #(
            .WIDTH  (32),
            .STAGES (g + 1),
            .OFF_W  (12)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .in_valid      (in_valid[g]),
            .in_ready      (in_ready[g]),
            .val_rm        (val_rm),
            .val_rs        (val_rs),
            .shift_operand (shift_operand),
            .immediate     (immediate),
            .mem_type      (mem_type),
            .carry_in      (carry_in),
            .out_valid     (out_valid[g]),
            .out_ready     (out_ready),
            .second_value  (sv[g]),
            .carry_out     (co[g])
        );
    end

    // Bit-serial reference: each step shifts one position and records the bit that falls out.
    function automatic logic [32:0] model(input logic [31:0] rm, input logic [7:0] rs,
                                          input logic [11:0] op, input logic imm,
                                          input logic mem, input logic cin);
        logic [31:0] r;
        logic        c;
        int          a;
        r = rm;
        c = cin;
        if (mem) begin
            r = {{20{op[11]}}, op};
        end else if (imm) begin
            r = {24'd0, op[7:0]};
            for (int k = 0; k < 2 * int'(op[11:8]); k++) r = {r[0], r[31:1]};
            if (op[11:8] != 4'd0) c = r[31];
        end else begin
            a = op[4] ? int'(rs) : int'(op[11:7]);
            if (!op[4] && a == 0) begin
                case (op[6:5])
                    2'b01:   begin r = '0; c = rm[31]; end
                    2'b10:   begin r = {32{rm[31]}}; c = rm[31]; end
                    2'b11:   begin r = {cin, rm[31:1]}; c = rm[0]; end
                    default: ;
                endcase
            end else begin
                for (int k = 0; k < a; k++) begin
                    case (op[6:5])
                        2'b00:   begin c = r[31]; r = {r[30:0], 1'b0}; end
                        2'b01:   begin c = r[0]; r = {1'b0, r[31:1]}; end
                        2'b10:   begin c = r[0]; r = {r[31], r[31:1]}; end
                        default: begin c = r[0]; r = {r[0], r[31:1]}; end
                    endcase
                end
            end
        end
        return {c, r};
    endfunction

    // Output side of the scoreboard: every drained beat must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid[d] && out_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL stray_beat dut%0d: got carry=%0b value=%h, required no beat", d, co[d], sv[d]);
                    end else begin
                        mon_exp = sb.pop_front();
                        if ({co[d], sv[d]} !== mon_exp) begin
                            n_fail++;
                            $display("FAIL result dut%0d: got carry=%0b value=%h, required carry=%0b value=%h",
                                     d, co[d], sv[d], mon_exp[32], mon_exp[31:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [31:0] rm, input logic [7:0] rs, input logic [11:0] op,
                        input logic imm, input logic mem, input logic cin, output int t_acc);
        bit done;
        val_rm        = rm;
        val_rs        = rs;
        shift_operand = op;
        immediate     = imm;
        mem_type      = mem;
        carry_in      = cin;
        in_valid[d]   = 1'b1;
        done          = 1'b0;
        t_acc         = 0;
        for (int w = 0; w < 50 && !done; w++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                sb.push_back(model(rm, rs, op, imm, mem, cin));
                t_acc = cyc;
                done  = 1'b1;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL accept_timeout dut%0d: in_ready stayed 0, required 1", d);
        end
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int w = 0; w < 40 && sb.size() != 0; w++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({out_valid[d], co[d], sv[d]} !== 34'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got valid=%0b carry=%0b value=%h, required all 0",
                         d, out_valid[d], co[d], sv[d]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 111", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency(input int d);
        int  t_acc;
        int  lat;
        bit  seen;
        out_ready = 1'b1;
        send(d, 32'hF000_000F, 8'd0, 12'h200, 1'b0, 1'b0, 1'b0, t_acc);
        seen = 1'b0;
        lat  = -1;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            if (out_valid[d]) begin
                seen = 1'b1;
                lat  = cyc - t_acc;
            end
        end
        n_checks++;
        if (lat != d + 1) begin
            n_fail++;
            $display("FAIL latency dut%0d: got %0d cycles, required %0d", d, lat, d + 1);
        end
        wait_drain("latency");
    endtask

    task automatic test_modes();
        int t;
        out_ready = 1'b1;
        send(1, 32'h8000_0001, 8'd0,   12'h020, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'h0000_0003, 8'd0,   12'h060, 1'b0, 1'b0, 1'b1, t);
        send(1, 32'hFFFF_FFFF, 8'd32,  12'h010, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'hFFFF_FFFF, 8'd40,  12'h010, 1'b0, 1'b0, 1'b1, t);
        send(1, 32'hFFFF_FFFF, 8'd0,   12'h010, 1'b0, 1'b0, 1'b1, t);
        send(1, 32'h1234_5678, 8'd0,   12'h4FF, 1'b1, 1'b0, 1'b0, t);
        send(1, 32'h1234_5678, 8'd0,   12'h0FF, 1'b1, 1'b0, 1'b0, t);
        send(1, 32'h1234_5678, 8'd0,   12'h800, 1'b0, 1'b1, 1'b0, t);
        send(1, 32'h8000_0000, 8'd0,   12'h040, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'h8000_0010, 8'd0,   12'h1C0, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'h0000_0003, 8'd0,   12'hF80, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'h8000_0001, 8'd32,  12'h070, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'h8000_0001, 8'd4,   12'h070, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'h8000_0000, 8'd32,  12'h030, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'h8000_0000, 8'd40,  12'h050, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'h0000_00F0, 8'd255, 12'h050, 1'b0, 1'b0, 1'b1, t);
        wait_drain("modes");
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp0;
        int          t;
        exp0      = model(32'h1111_1111, 8'd0, 12'h080, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(1, 32'h1111_1111 * (i + 1), 8'd0, 12'h080, 1'b0, 1'b0, 1'b0, t);
            end
            begin
                for (int k = 1; k <= 5; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (k < 3) begin
                        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
                            n_fail++;
                            $display("FAIL stall_fill cycle%0d: got valid=%0b ready=%0b, required valid=0 ready=1",
                                     k, out_valid[1], in_ready[1]);
                        end
                    end else if (out_valid[1] !== 1'b1 || {co[1], sv[1]} !== exp0 || in_ready[1] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stall_hold cycle%0d: got valid=%0b ready=%0b carry=%0b value=%h, required valid=1 ready=0 carry=%0b value=%h",
                                 k, out_valid[1], in_ready[1], co[1], sv[1], exp0[32], exp0[31:0]);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_valid[1] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL release_stream beat%0d: got valid=%0b, required 1", k, out_valid[1]);
                    end
                end
            end
        join
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_midflight();
        int t;
        out_ready = 1'b0;
        send(1, 32'hF000_000F, 8'd0, 12'h200, 1'b0, 1'b0, 1'b0, t);
        send(1, 32'hF000_000F, 8'd0, 12'h200, 1'b0, 1'b0, 1'b0, t);
        @(negedge clk);
        n_checks++;
        if (out_valid[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_full: got valid=%0b, required 1", out_valid[1]);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid[1], co[1], sv[1]} !== 34'd0 || in_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_reset: got valid=%0b carry=%0b value=%h ready=%0b, required 0 0 0 ready=1",
                     out_valid[1], co[1], sv[1], in_ready[1]);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 3'b000) begin
                n_fail++;
                $display("FAIL midflight_stale cycle%0d: got out_valid=%b, required 000", k, out_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int t;
        rnd_stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(1, $urandom, ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 40)),
                         12'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                         1'($urandom_range(0, 1)), t);
                end
                rnd_stop = 1'b1;
            end
            begin
                while (!rnd_stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("random");
    endtask

    initial begin
        test_reset();
        test_latency(1);
        test_modes();
        test_back_to_back();
        test_reset_midflight();
        test_latency(0);
        test_latency(2);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
